gpio_wb_n: RTL and testbench
============================

GPIO_WB_N -- requirements
Module: gpio_wb_n

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h2100_0000; Wishbone base address; bits [7:0] SHALL be zero.
REQ-002 SHALL have parameter NPINS, default 16; pin count, legal range 1..32.
REQ-003 SHALL have one clock and a synchronous, active-high reset: wb_clk_i  input  1  sole clock, all state on rising edge; wb_rst_i  input  1  synchronous active-high reset.
REQ-004 SHALL have ports wb_stb_i input 1 strobe; wb_cyc_i input 1 cycle; wb_we_i input 1 write enable; wb_sel_i input 4 byte selects.
REQ-005 SHALL have ports wb_adr_i input 32 byte address; wb_dat_i input 32 write data; wb_dat_o output 32 read data; wb_ack_o output 1 acknowledge.
REQ-006 SHALL have ports gpio_in_pad input NPINS raw asynchronous pad inputs; gpio_out_pad output NPINS output data; gpio_oeb output NPINS output-enable-bar (1 = pad is an input).
REQ-007 SHALL have ports gpio_pu output NPINS pull-up enables; gpio_pd output NPINS pull-down enables; irq output 1 level interrupt.

Function
REQ-008 SHALL decode the register map at BASE_ADR + offset: 0x00 IN (RO), 0x04 OUT, 0x08 OEB, 0x0C PU, 0x10 PD, 0x14 RISE_EN, 0x18 FALL_EN, 0x1C STAT (W1C).
REQ-009 SHALL select the block when wb_adr_i[31:8] == BASE_ADR[31:8]; no other address SHALL cause wb_ack_o.
REQ-010 SHALL, for a selected access with wb_stb_i & wb_cyc_i & !wb_ack_o, assert wb_ack_o for exactly one cycle, on the following rising edge.
REQ-011 SHALL perform the register write on the same edge that raises wb_ack_o, honouring wb_sel_i per byte; bits at or above NPINS SHALL be ignored.
REQ-012 SHALL present read data on wb_dat_o in the wb_ack_o cycle; bits at or above NPINS SHALL read 0.
REQ-013 SHALL read 0 and ack normally for unmapped offsets inside the window; writes there SHALL have no effect.
REQ-014 SHALL ignore writes to IN.
REQ-015 SHALL pass each gpio_in_pad bit through a 2-flop synchronizer; IN SHALL reflect a pad change 2 cycles after the first sampling edge.
REQ-016 SHALL hold a third delayed copy of each input; rise = sync & !prev, fall = !sync & prev.
REQ-017 SHALL set STAT[i] on the edge after (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); STAT[i] SHALL be sticky until cleared.
REQ-018 SHALL clear STAT[i] when a 1 is written to bit i; a set event in the same cycle SHALL take priority, leaving STAT[i] = 1.
REQ-019 SHALL never set STAT on pin-enable changes alone; clearing RISE_EN/FALL_EN SHALL NOT clear STAT.
REQ-020 SHALL drive irq = |STAT, registered; no further gating.
REQ-021 SHALL drive gpio_out_pad, gpio_oeb, gpio_pu and gpio_pd directly from the OUT, OEB, PU and PD registers; the outputs SHALL be independent of pin direction.

Reset
REQ-022 SHALL, while wb_rst_i = 1 at a clock edge, set OUT = 0, OEB = all 1s, PU = 0, PD = 0, RISE_EN = 0, FALL_EN = 0 and STAT = 0.
REQ-023 SHALL, under reset, also set the synchronizer and delay flops to 0 and drive wb_ack_o = 0, wb_dat_o = 0 and irq = 0.
REQ-024 SHALL abandon any in-flight access if reset is asserted mid-access: no ack and no register update.
REQ-025 SHALL NOT set STAT on the first cycles after reset, even if pads are already high, because edge enables reset to 0.

Structure
REQ-026 SHALL keep the register offsets (0x00..0x1C) in a shared include file gpio_wb_n_defs.vh, used by both RTL and bench.
REQ-027 SHALL implement the per-pin synchronizer, delay flop and rise/fall detection in sub-module gpio_sync_edge, instantiated NPINS times via generate.

Verification
REQ-028 The bench SHALL cover: reset, then read OEB, OUT and STAT -> 0x0000FFFF, 0x00000000 and 0x00000000, with irq = 0.
REQ-029 The bench SHALL cover: write OUT = 0x0000A5A5 with sel = 4'b0001, then read -> 0x000000A5, ack high exactly one cycle per access.
REQ-030 The bench SHALL cover: gpio_in_pad = 16'h0003, then read IN 3+ cycles later -> 0x00000003; write IN = 0xFFFF -> IN is unchanged.
REQ-031 The bench SHALL cover: RISE_EN = 0x1, pad[0] 0->1 -> STAT = 0x1 and irq = 1 within 4 cycles; write STAT = 0x1 -> STAT = 0, irq = 0.
REQ-032 The bench SHALL cover: FALL_EN = 0x2, pad[1] 1->0 timed so the edge event and a W1C of bit 1 land in the same cycle -> STAT[1] = 1.
REQ-033 The bench SHALL cover: access BASE_ADR + 0x100 -> no ack (bench timeout guard); access BASE_ADR + 0x40 -> ack with read 0.

Source files
------------

// File: rtl/gpio_wb_n_pkg.sv
// Shared offsets and helpers for the GPIO Wishbone block.
package gpio_wb_n_pkg;
`include "gpio_wb_n_defs.vh"

    localparam logic [7:0] OFF_IN      = `GPIO_WB_N_OFF_IN;
    localparam logic [7:0] OFF_OUT     = `GPIO_WB_N_OFF_OUT;
    localparam logic [7:0] OFF_OEB     = `GPIO_WB_N_OFF_OEB;
    localparam logic [7:0] OFF_PU      = `GPIO_WB_N_OFF_PU;
    localparam logic [7:0] OFF_PD      = `GPIO_WB_N_OFF_PD;
    localparam logic [7:0] OFF_RISE_EN = `GPIO_WB_N_OFF_RISE_EN;
    localparam logic [7:0] OFF_FALL_EN = `GPIO_WB_N_OFF_FALL_EN;
    localparam logic [7:0] OFF_STAT    = `GPIO_WB_N_OFF_STAT;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction
endpackage

// File: rtl/gpio_sync_edge.sv
// One pin: 2-flop synchronizer, a delayed copy, and rise/fall detect.
module gpio_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pad_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/gpio_wb_n_defs.vh
// Register byte offsets inside the GPIO Wishbone window.
`ifndef GPIO_WB_N_DEFS_VH
`define GPIO_WB_N_DEFS_VH
`define GPIO_WB_N_OFF_IN      8'h00
`define GPIO_WB_N_OFF_OUT     8'h04
`define GPIO_WB_N_OFF_OEB     8'h08
`define GPIO_WB_N_OFF_PU      8'h0C
`define GPIO_WB_N_OFF_PD      8'h10
`define GPIO_WB_N_OFF_RISE_EN 8'h14
`define GPIO_WB_N_OFF_FALL_EN 8'h18
`define GPIO_WB_N_OFF_STAT    8'h1C
`endif

// File: rtl/gpio_wb_n.sv
// Wishbone-slave GPIO: data/direction/pull registers plus sticky edge status and irq.
module gpio_wb_n
    import gpio_wb_n_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h2100_0000,
    parameter int          NPINS    = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [NPINS-1:0] gpio_in_pad,
    output logic [NPINS-1:0] gpio_out_pad,
    output logic [NPINS-1:0] gpio_oeb,
    output logic [NPINS-1:0] gpio_pu,
    output logic [NPINS-1:0] gpio_pd,
    output logic             irq
);
    logic [NPINS-1:0] in_sync, rise, fall;

    for (genvar g = 0; g < NPINS; g++) begin : g_pin
        gpio_sync_edge u_se (
            .clk_i  (wb_clk_i),
            .rst_i  (wb_rst_i),
            .pad_i  (gpio_in_pad[g]),
            .sync_o (in_sync[g]),
            .rise_o (rise[g]),
            .fall_o (fall[g])
        );
    end

    logic [NPINS-1:0] out_q, oeb_q, pu_q, pd_q, ren_q, fen_q, stat_q;
    logic [NPINS-1:0] out_d, oeb_d, pu_d, pd_d, ren_d, fen_d, stat_d;
    logic             ack_q, irq_q;
    logic [31:0]      dat_q, rdata, mask32;
    logic [NPINS-1:0] m_n, d_n, w1c, evt;
    logic [7:0]       off;
    logic             req, wr;
    logic             unused_bits;

    // The !ack term makes each request produce exactly one ack pulse.
    assign req    = wb_stb_i & wb_cyc_i & ~ack_q & (wb_adr_i[31:8] == BASE_ADR[31:8]);
    assign wr     = req & wb_we_i;
    assign off    = wb_adr_i[7:0];
    assign mask32 = sel_mask(wb_sel_i);
    assign m_n    = mask32[NPINS-1:0];
    assign d_n    = wb_dat_i[NPINS-1:0];
    assign evt    = (rise & ren_q) | (fall & fen_q);
    assign w1c    = (wr && off == OFF_STAT) ? (d_n & m_n) : '0;
    assign unused_bits = ^{wb_dat_i, mask32, BASE_ADR[7:0]};

    always_comb begin
        out_d  = out_q;
        oeb_d  = oeb_q;
        pu_d   = pu_q;
        pd_d   = pd_q;
        ren_d  = ren_q;
        fen_d  = fen_q;
        // A same-cycle edge event wins over the W1C clear.
        stat_d = (stat_q & ~w1c) | evt;
        if (wr) begin
            case (off)
                OFF_OUT:     out_d = (out_q & ~m_n) | (d_n & m_n);
                OFF_OEB:     oeb_d = (oeb_q & ~m_n) | (d_n & m_n);
                OFF_PU:      pu_d  = (pu_q  & ~m_n) | (d_n & m_n);
                OFF_PD:      pd_d  = (pd_q  & ~m_n) | (d_n & m_n);
                OFF_RISE_EN: ren_d = (ren_q & ~m_n) | (d_n & m_n);
                OFF_FALL_EN: fen_d = (fen_q & ~m_n) | (d_n & m_n);
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_IN:      rdata = 32'(in_sync);
            OFF_OUT:     rdata = 32'(out_q);
            OFF_OEB:     rdata = 32'(oeb_q);
            OFF_PU:      rdata = 32'(pu_q);
            OFF_PD:      rdata = 32'(pd_q);
            OFF_RISE_EN: rdata = 32'(ren_q);
            OFF_FALL_EN: rdata = 32'(fen_q);
            OFF_STAT:    rdata = 32'(stat_q);
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q  <= '0;
            oeb_q  <= '1;
            pu_q   <= '0;
            pd_q   <= '0;
            ren_q  <= '0;
            fen_q  <= '0;
            stat_q <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            oeb_q  <= oeb_d;
            pu_q   <= pu_d;
            pd_q   <= pd_d;
            ren_q  <= ren_d;
            fen_q  <= fen_d;
            stat_q <= stat_d;
            ack_q  <= req;
            dat_q  <= req ? rdata : '0;
            irq_q  <= |stat_d;
        end
    end

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_q;
    assign irq          = irq_q;
    assign gpio_out_pad = out_q;
    assign gpio_oeb     = oeb_q;
    assign gpio_pu      = pu_q;
    assign gpio_pd      = pd_q;
endmodule

// File: tb/tb_gpio_wb_n.sv
// Scoreboard bench for gpio_wb_n: expected read data queued at issue, checked at ack.
module tb_gpio_wb_n;
    localparam logic [31:0] BASE = 32'h2100_0000;
    localparam int NP = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wb_stb_i, wb_cyc_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_ack_o, irq;
    logic [NP-1:0] gpio_in_pad, gpio_out_pad, gpio_oeb, gpio_pu, gpio_pd;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic        irq_seen;

    gpio_wb_n #(.BASE_ADR(BASE), .NPINS(NP)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wb_stb_i    (wb_stb_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .gpio_in_pad (gpio_in_pad),
        .gpio_out_pad(gpio_out_pad),
        .gpio_oeb    (gpio_oeb),
        .gpio_pu     (gpio_pu),
        .gpio_pd     (gpio_pd),
        .irq         (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a clock edge; drives the request immediately.
    task automatic wb_cycle(input string tag, input logic [31:0] adr, input logic we,
                            input logic [3:0] sel, input logic [31:0] dat, input logic exp_ack);
        logic        acked;
        logic [31:0] rd;
        logic [31:0] e;
        acked = 1'b0;
        rd    = '0;
        wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i); #1;
            if (wb_ack_o) begin
                acked = 1'b1;
                rd    = wb_dat_o;
                break;
            end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        if (!exp_ack) begin
            chk({tag, "_noack"}, {31'b0, acked}, 32'd0);
            return;
        end
        chk({tag, "_ack"}, {31'b0, acked}, 32'd1);
        if (acked) begin
            @(posedge wb_clk_i); #1;
            chk({tag, "_ack1cyc"}, {31'b0, wb_ack_o}, 32'd0);
        end
        if (!we) begin
            e = exp_q.pop_front();
            if (acked) chk({tag, "_rd"}, rd, e);
        end
    endtask

    task automatic wb_wr(input string tag, input logic [7:0] off, input logic [3:0] sel,
                         input logic [31:0] dat);
        wb_cycle(tag, BASE + {24'h0, off}, 1'b1, sel, dat, 1'b1);
    endtask

    task automatic wb_rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
        exp_q.push_back(exp);
        wb_cycle(tag, BASE + {24'h0, off}, 1'b0, 4'hF, 32'h0, 1'b1);
    endtask

    initial begin
        wb_rst_i = 1'b1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = 4'h0; wb_adr_i = '0; wb_dat_i = '0;
        gpio_in_pad = '0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        wb_rd("oeb_rst", `GPIO_WB_N_OFF_OEB, 32'h0000_FFFF);
        wb_rd("out_rst", `GPIO_WB_N_OFF_OUT, 32'h0);
        wb_rd("stat_rst", `GPIO_WB_N_OFF_STAT, 32'h0);
        chk("irq_rst", {31'b0, irq}, 32'd0);
        chk("oeb_pad_rst", {16'h0, gpio_oeb}, 32'h0000_FFFF);

        // Byte-select write and bits above NPINS
        wb_wr("out_wr", `GPIO_WB_N_OFF_OUT, 4'b0001, 32'h0000_A5A5);
        wb_rd("out_sel", `GPIO_WB_N_OFF_OUT, 32'h0000_00A5);
        chk("out_pad", {16'h0, gpio_out_pad}, 32'h0000_00A5);
        wb_wr("pu_wr", `GPIO_WB_N_OFF_PU, 4'hF, 32'h1234_5678);
        wb_rd("pu_rd", `GPIO_WB_N_OFF_PU, 32'h0000_5678);
        chk("pu_pad", {16'h0, gpio_pu}, 32'h0000_5678);

        // Input sync; IN is read-only; edges with no enables never set STAT
        gpio_in_pad = 16'h0003;
        repeat (4) @(posedge wb_clk_i);
        #1;
        wb_rd("in_rd", `GPIO_WB_N_OFF_IN, 32'h0000_0003);
        wb_wr("in_wr", `GPIO_WB_N_OFF_IN, 4'hF, 32'h0000_FFFF);
        wb_rd("in_ro", `GPIO_WB_N_OFF_IN, 32'h0000_0003);
        gpio_in_pad = 16'h0000;
        repeat (5) @(posedge wb_clk_i);
        #1;
        wb_rd("stat_noen", `GPIO_WB_N_OFF_STAT, 32'h0);

        // Rising edge on pin 0
        wb_wr("ren_wr", `GPIO_WB_N_OFF_RISE_EN, 4'hF, 32'h1);
        gpio_in_pad = 16'h0001;
        irq_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk_i); #1;
            if (irq) begin
                irq_seen = 1'b1;
                break;
            end
        end
        chk("irq_rise", {31'b0, irq_seen}, 32'd1);
        wb_rd("stat_rise", `GPIO_WB_N_OFF_STAT, 32'h1);
        wb_wr("stat_w1c", `GPIO_WB_N_OFF_STAT, 4'hF, 32'h1);
        wb_rd("stat_clr", `GPIO_WB_N_OFF_STAT, 32'h0);
        chk("irq_clr", {31'b0, irq}, 32'd0);

        // Falling edge on pin 1 colliding with a W1C of bit 1
        wb_wr("fen_wr", `GPIO_WB_N_OFF_FALL_EN, 4'hF, 32'h2);
        gpio_in_pad = 16'h0002;
        repeat (5) @(posedge wb_clk_i);
        #1;
        wb_rd("stat_pre", `GPIO_WB_N_OFF_STAT, 32'h0);
        gpio_in_pad = 16'h0000;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_wr("stat_race", `GPIO_WB_N_OFF_STAT, 4'hF, 32'h2);
        wb_rd("stat_setwin", `GPIO_WB_N_OFF_STAT, 32'h2);
        chk("irq_setwin", {31'b0, irq}, 32'd1);
        wb_wr("fen_off", `GPIO_WB_N_OFF_FALL_EN, 4'hF, 32'h0);
        wb_rd("stat_sticky", `GPIO_WB_N_OFF_STAT, 32'h2);
        wb_wr("stat_w1c2", `GPIO_WB_N_OFF_STAT, 4'hF, 32'h2);
        wb_rd("stat_clr2", `GPIO_WB_N_OFF_STAT, 32'h0);

        // Address decode
        wb_cycle("outside", BASE + 32'h100, 1'b0, 4'hF, 32'h0, 1'b0);
        wb_wr("unmap_wr", 8'h40, 4'hF, 32'hFFFF_FFFF);
        wb_rd("unmap_rd", 8'h40, 32'h0);
        wb_rd("out_keep", `GPIO_WB_N_OFF_OUT, 32'h0000_00A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
